data_mem_ctrl: RTL and testbench

//  Multicycle data-memory access unit; sits directly upstream of the memory data register (MDR).

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_ram.sv | 43 ++++
 rtl/data_mem_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//    Shared definitions for the data-memory access unit:
//    - access size encodings (byte / half / word / reserved)
//    - controller state encoding
//    - load_extract(): selects the addressed lane of a 32-bit RAM word and
//      zero- or sign-extends it to 32 bits (little-endian lane numbering)
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // lane is the byte offset within the word (addr[1:0]); alignment has
   // already been enforced, so a half access only looks at lane[1].
   function automatic logic [31:0] load_extract(
      input logic [31:0] word,
      input logic [1:0]  lane,
      input logic [1:0]  size,
      input logic        sext
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*lane +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: r = {{24{sext & b[7]}}, b};
         SIZE_HALF: r = {{16{sext & h[15]}}, h};
         default:   r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
//    Single-port 2**ADDR_W x 32 RAM split into four independent byte lanes.
//    Writes are synchronous and gated per lane by be_i; reads are
//    asynchronous so the controller can extract load data on its commit edge.
//    Contents are never reset.
// Ports:
//    clk      in   clock
//    we_i     in   write strobe
//    be_i     in   [3:0] byte enables, bit n covers bits [8n+7:8n]
//    addr_i   in   [ADDR_W-1:0] word address
//    wdata_i  in   [31:0] write data (already replicated across lanes)
//    rdata_o  out  [31:0] read data of the addressed word
// -----------------------------------------------------------------------------
module dmem_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [3:0]        be_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH];

         always_ff @(posedge clk) begin
            if (we_i && be_i[gi]) begin
               mem_q[addr_i] <= wdata_i[8*gi +: 8];
            end
         end

         assign rdata_o[8*gi +: 8] = mem_q[addr_i];
      end
   endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//    Multicycle load/store unit in front of the memory data register.
//    Accepts one request in IDLE, checks alignment and range, spends LATENCY
//    cycles in BUSY and commits the access on the last BUSY edge, then pulses
//    done for one cycle (with err on rejected requests). data_out only ever
//    changes on a successful load commit (or reset).
// Ports:
//    clk       in   clock
//    rst       in   synchronous active-high reset
//    req       in   request strobe, sampled only in IDLE
//    we        in   1 = store, 0 = load
//    size      in   [1:0] 00 byte, 01 half, 10 word, 11 reserved
//    sext      in   loads: 1 = sign-extend, 0 = zero-extend
//    addr      in   [31:0] byte address
//    data_in   in   [31:0] right-aligned store data
//    busy      out  high while in BUSY
//    done      out  one-cycle completion pulse
//    err       out  high with done when the request was rejected
//    data_out  out  [31:0] last successful load result
// -----------------------------------------------------------------------------
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sext,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] data_out
);

   // Counter only has to hold LATENCY-1.
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   // Byte-address width covered by the RAM; anything above must be zero.
   localparam int BA_W  = ADDR_W + 2;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [BA_W-1:0]   addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       dout_q, dout_d;

   logic              req_bad;
   logic              commit;
   logic              ram_we;
   logic [3:0]        ram_be;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   // Request screening on the live inputs, evaluated when IDLE accepts.
   always_comb begin
      req_bad = (addr[31:BA_W] != '0);
      case (size)
         SIZE_HALF: req_bad = req_bad | addr[0];
         SIZE_WORD: req_bad = req_bad | (addr[1:0] != 2'b00);
         SIZE_RSVD: req_bad = 1'b1;
         default:   ;
      endcase
   end

   assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

   // Next-state, operand latches and registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sext_d  = sext_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               sext_d  = sext;
               addr_d  = addr[BA_W-1:0];
               wdata_d = data_in;
               if (req_bad) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  dout_d = load_extract(ram_rdata, addr_q[1:0], size_q, sext_q);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they appear registered
      // in the same cycle the FSM occupies that state.
      busy_d = (state_d == ST_BUSY);
      done_d = (state_d == ST_DONE) || (state_d == ST_ERR);
      err_d  = (state_d == ST_ERR);
   end

   // Store lane steering: replicate data, enable only the addressed lanes.
   always_comb begin
      case (size_q)
         SIZE_BYTE: begin
            ram_be    = 4'b0001 << addr_q[1:0];
            ram_wdata = {4{wdata_q[7:0]}};
         end
         SIZE_HALF: begin
            ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{wdata_q[15:0]}};
         end
         default: begin
            ram_be    = 4'b1111;
            ram_wdata = wdata_q;
         end
      endcase
   end

   // Reset on the commit edge must win over the write, so gate with rst.
   assign ram_we = commit && we_q && !rst;

   dmem_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .be_i    (ram_be),
      .addr_i  (addr_q[BA_W-1:2]),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SIZE_BYTE;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign data_out = dout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//    Directed scenarios plus randomized traffic against a byte-array
//    reference model of the memory and the expected load result.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;
   import dmem_pkg::*;

   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;
   localparam int NBYTES  = 4 << ADDR_W;

   logic        clk = 1'b0;
   logic        rst, req, we, sext;
   logic [1:0]  size;
   logic [31:0] addr, data_in;
   logic        busy, done, err;
   logic [31:0] data_out;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [7:0]  mref [NBYTES];
   logic [31:0] exp_dout;

   always #5 clk = ~clk;

   data_mem_ctrl #(
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .size     (size),
      .sext     (sext),
      .addr     (addr),
      .data_in  (data_in),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .data_out (data_out)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit model_bad(input logic [1:0] sz, input logic [31:0] a);
      longint nb;
      if (sz == 2'd3) return 1'b1;
      nb = longint'(1) << sz;
      if ((longint'(a) % nb) != 0) return 1'b1;
      return (longint'(a) + nb) > NBYTES;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
      longint v;
      int     nb;
      nb = 1 << sz;
      v  = 0;
      for (int i = 0; i < nb; i++) v += longint'(mref[a + i]) << (8 * i);
      if (sx && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
      int nb;
      nb = 1 << sz;
      for (int i = 0; i < nb; i++) mref[a + i] = 8'(d >> (8 * i));
   endtask

   // ---------------- one transaction ----------------
   // Entered #1 after a posedge with the DUT idle; returns the same way.
   task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d);
      bit bad;
      int n_busy;
      int lat;
      bad = model_bad(sz, a);
      req = 1'b1; we = w; size = sz; sext = sx; addr = a; data_in = d;
      @(posedge clk); #1;
      // Scramble operands and hold req for one more edge: must be ignored.
      req = 1'b1; we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
      addr = $urandom; data_in = $urandom;
      n_busy = 0;
      lat    = -1;
      for (int n = 0; n < 20; n++) begin
         if (n == 1) req = 1'b0;
         if (busy) n_busy++;
         if (done) begin
            lat = n;
            break;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      if (lat < 0) chk_eq("done_timeout", 32'(lat), 32'(bad ? 0 : LATENCY));
      else         chk_eq("latency", 32'(lat), 32'(bad ? 0 : LATENCY));
      chk_eq("err", {31'b0, err}, {31'b0, bad});
      chk_eq("busy_cycles", 32'(n_busy), 32'(bad ? 0 : LATENCY));
      if (!bad) begin
         if (w) model_store(sz, a, d);
         else   exp_dout = model_load(sz, sx, a);
      end
      chk_eq("data_out", data_out, exp_dout);
      @(posedge clk); #1;
      chk_eq("done_pulse", {31'b0, done}, 32'd0);
      $display("op %s sz=%0d sx=%0b a=%h d=%h -> err=%0b lat=%0d dout=%h",
               w ? "ST" : "LD", sz, sx, a, d, err, lat, data_out);
   endtask

   // Store interrupted by reset: at_commit=0 -> rst on first BUSY edge,
   // at_commit=1 -> rst on the commit edge. Either way nothing is written.
   task automatic rst_mid_store(input logic [31:0] a, input logic [31:0] d, input bit at_commit);
      req = 1'b1; we = 1'b1; size = SIZE_WORD; sext = 1'b0; addr = a; data_in = d;
      @(posedge clk); #1;
      req = 1'b0;
      chk_eq("rst_busy_before", {31'b0, busy}, 32'd1);
      if (at_commit) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_dout = '0;
      chk_eq("rst_busy", {31'b0, busy}, 32'd0);
      chk_eq("rst_done", {31'b0, done}, 32'd0);
      chk_eq("rst_err",  {31'b0, err},  32'd0);
      chk_eq("rst_dout", data_out, 32'd0);
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         chk_eq("rst_no_done", {31'b0, done}, 32'd0);
      end
      $display("rst mid-store a=%h at_commit=%0b", a, at_commit);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      rst = 1'b1; req = 1'b0; we = 1'b0; size = '0; sext = 1'b0;
      addr = '0; data_in = '0; exp_dout = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_eq("reset_busy", {31'b0, busy}, 32'd0);
      chk_eq("reset_done", {31'b0, done}, 32'd0);
      chk_eq("reset_err",  {31'b0, err},  32'd0);
      chk_eq("reset_dout", data_out, 32'd0);

      // Give the first 64 words known contents.
      for (int i = 0; i < 64; i++) do_op(1'b1, SIZE_WORD, 1'b0, 32'(i * 4), $urandom);

      // Reset while idle with a non-zero data_out.
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h4, 32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_dout = '0;
      chk_eq("idle_rst_busy", {31'b0, busy}, 32'd0);
      chk_eq("idle_rst_done", {31'b0, done}, 32'd0);
      chk_eq("idle_rst_err",  {31'b0, err},  32'd0);
      chk_eq("idle_rst_dout", data_out, 32'd0);

      // Word store then load.
      do_op(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0);
      chk_eq("t2_word", data_out, 32'hDEADBEEF);

      // Sub-word loads with extension.
      do_op(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0);
      chk_eq("t3_byte_sext", data_out, 32'hFFFFFFDE);
      do_op(1'b0, SIZE_BYTE, 1'b0, 32'h13, 32'h0);
      chk_eq("t3_byte_zext", data_out, 32'h000000DE);
      do_op(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0);
      chk_eq("t3_half_sext", data_out, 32'hFFFFDEAD);

      // Byte store merges into one lane only; upper data_in bits are ignored.
      do_op(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'hABCDEF55);
      chk_eq("t4_store_keeps_dout", data_out, 32'hFFFFDEAD);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0);
      chk_eq("t4_merge", data_out, 32'hDEAD55EF);

      // Rejected requests.
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h12, 32'h0);
      do_op(1'b0, SIZE_RSVD, 1'b0, 32'h10, 32'h0);
      chk_eq("t5_dout_kept", data_out, 32'hDEAD55EF);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0);
      chk_eq("t5_reload", data_out, 32'hDEAD55EF);

      // Reset during a store.
      rst_mid_store(32'h20, 32'h12345678, 1'b0);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0);
      rst_mid_store(32'h24, 32'hCAFEF00D, 1'b1);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'h24, 32'h0);

      // Top of the address range and just past it.
      do_op(1'b1, SIZE_WORD, 1'b0, 32'hFFC, 32'h8BADF00D);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'hFFC, 32'h0);
      do_op(1'b1, SIZE_HALF, 1'b0, 32'hFFE, 32'h0000F1E2);
      do_op(1'b0, SIZE_BYTE, 1'b1, 32'hFFF, 32'h0);
      do_op(1'b0, SIZE_HALF, 1'b1, 32'hFFE, 32'h0);
      do_op(1'b0, SIZE_BYTE, 1'b0, 32'h1000, 32'h0);
      do_op(1'b1, SIZE_HALF, 1'b0, 32'h80000000, 32'hFFFF);
      do_op(1'b0, SIZE_WORD, 1'b0, 32'hFFC, 32'h0);

      // Randomized traffic over the initialised region plus out-of-range hits.
      for (int i = 0; i < 200; i++) begin
         rsz = ($urandom_range(0, 15) == 0) ? SIZE_RSVD : 2'($urandom_range(0, 2));
         ra  = ($urandom_range(0, 19) == 0) ? ($urandom | 32'h1000) : 32'($urandom_range(0, 255));
         do_op(1'($urandom), rsz, 1'($urandom), ra, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
